// File: rtl/i2c_tca6416a_pkg.sv
// Shared TCA6416A constants: command bytes, bit-phase count, slave-address prefix and sequencer states.
package i2c_tca6416a_pkg;
  localparam logic [7:0] CMD_OUTPUT_PORT0  = 8'h02;
  localparam logic [7:0] CMD_CONFIG_PORT0  = 8'h06;
  localparam int         PHASE_COUNT       = 4;
  localparam logic [5:0] SLAVE_ADDR_PREFIX = 6'b010000;

  typedef enum logic [2:0] {
    ST_INIT_CFG0,
    ST_INIT_CFG1,
    ST_INIT_OUT0,
    ST_INIT_OUT1,
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_STOP
  } state_t;
endpackage

// File: rtl/i2c_tca6416a_sequencer_bit_phase_gen.sv
// Bit-phase timebase: one-cycle strobe every CLOCK_DIV cycles, first one CLOCK_DIV cycles after reset.
// The phase advances on the edge that ends the strobe, so phase p is valid alongside its strobe.
module i2c_bit_phase_gen
  import i2c_tca6416a_pkg::*;
#(
  parameter int CLOCK_DIV = 125
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  output logic [1:0] bit_phase_o,
  output logic       bit_phase_inc_o
);
  localparam logic [11:0] TERMINAL = 12'(CLOCK_DIV - 1);
  localparam logic [1:0]  PHASE_STEP = 2'(PHASE_COUNT + 1);

  logic [11:0] r_presc;
  logic        r_inc;
  logic [1:0]  r_phase;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_presc <= 12'd0;
      r_inc   <= 1'b0;
      r_phase <= 2'd0;
    end else begin
      if (r_presc == TERMINAL) begin
        r_presc <= 12'd0;
        r_inc   <= 1'b1;
      end else begin
        r_presc <= r_presc + 12'd1;
        r_inc   <= 1'b0;
      end
      if (r_inc) r_phase <= r_phase + PHASE_STEP;
    end
  end

  assign bit_phase_o     = r_phase;
  assign bit_phase_inc_o = r_inc;
endmodule

// File: rtl/i2c_tca6416a_sequencer.sv
// Sequences TCA6416A writes: fixed config/output init of both units, then dirty-driven output refreshes.
// start_o is held until accepted on the phase-3 strobe; the next write waits for the writer's stop_i.
module i2c_tca6416a_sequencer
  import i2c_tca6416a_pkg::*;
#(
  parameter int          CLOCK_DIV    = 125,
  parameter logic [15:0] UNIT0_CONFIG = 16'h0000,
  parameter logic [15:0] UNIT1_CONFIG = 16'h0000
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic [7:0] out0_p0_i,
  input  logic [7:0] out0_p1_i,
  input  logic [7:0] out1_p0_i,
  input  logic [7:0] out1_p1_i,
  input  logic       refresh_i,
  input  logic       stop_i,
  output logic [1:0] bit_phase_o,
  output logic       bit_phase_inc_o,
  output logic       unit_o,
  output logic [7:0] command_o,
  output logic [7:0] data_0_o,
  output logic [7:0] data_1_o,
  output logic       start_o,
  output logic       ready_o,
  output logic       busy_o
);
  state_t      r_state, w_next, r_after, w_after;
  logic        r_unit, r_last_unit, r_ready;
  logic [7:0]  r_cmd, r_d0, r_d1;
  logic [15:0] r_shadow0, r_shadow1;
  logic [1:0]  r_refresh, w_refresh_nxt;
  logic        w_issue, w_issue_unit, w_dirty0, w_dirty1;
  logic [7:0]  w_cmd;
  logic [15:0] w_payload, w_req0, w_req1;

  i2c_bit_phase_gen #(.CLOCK_DIV(CLOCK_DIV)) u_phase_gen (
    .clock_i        (clock_i),
    .reset_n_i      (reset_n_i),
    .bit_phase_o    (bit_phase_o),
    .bit_phase_inc_o(bit_phase_inc_o)
  );

  assign w_req0   = {out0_p1_i, out0_p0_i};
  assign w_req1   = {out1_p1_i, out1_p0_i};
  assign w_dirty0 = (w_req0 != r_shadow0) || r_refresh[0];
  assign w_dirty1 = (w_req1 != r_shadow1) || r_refresh[1];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= ST_INIT_CFG0;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_issue      = 1'b0;
    w_issue_unit = 1'b0;
    w_cmd        = CMD_OUTPUT_PORT0;
    w_payload    = w_req0;
    w_after      = ST_IDLE;
    case (r_state)
      ST_INIT_CFG0: begin
        w_issue = 1'b1; w_cmd = CMD_CONFIG_PORT0; w_payload = UNIT0_CONFIG; w_after = ST_INIT_CFG1;
      end
      ST_INIT_CFG1: begin
        w_issue = 1'b1; w_issue_unit = 1'b1; w_cmd = CMD_CONFIG_PORT0;
        w_payload = UNIT1_CONFIG; w_after = ST_INIT_OUT0;
      end
      ST_INIT_OUT0: begin
        w_issue = 1'b1; w_after = ST_INIT_OUT1;
      end
      ST_INIT_OUT1: begin
        w_issue = 1'b1; w_issue_unit = 1'b1; w_payload = w_req1;
      end
      ST_IDLE: begin
        // On contention the unit not written last goes first.
        if (w_dirty0 || w_dirty1) begin
          w_issue      = 1'b1;
          w_issue_unit = w_dirty1 && (!w_dirty0 || !r_last_unit);
          w_payload    = w_issue_unit ? w_req1 : w_req0;
        end
      end
      ST_LAUNCH:    if (bit_phase_o == 2'd3 && bit_phase_inc_o) w_next = ST_WAIT_STOP;
      ST_WAIT_STOP: if (stop_i) w_next = r_after;
      default:      w_next = ST_INIT_CFG0;
    endcase
    if (w_issue) w_next = ST_LAUNCH;
  end

  always_comb begin
    start_o = (r_state == ST_LAUNCH);
    busy_o  = (r_state == ST_LAUNCH) || (r_state == ST_WAIT_STOP);
  end

  // A refresh in the same cycle as a snapshot re-marks the unit, so it is written once more.
  always_comb begin
    w_refresh_nxt = r_refresh;
    if (w_issue && w_cmd == CMD_OUTPUT_PORT0) w_refresh_nxt[w_issue_unit] = 1'b0;
    if (refresh_i) w_refresh_nxt = 2'b11;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_unit      <= 1'b0;
      r_last_unit <= 1'b0;
      r_cmd       <= 8'h00;
      r_d0        <= 8'h00;
      r_d1        <= 8'h00;
      r_after     <= ST_INIT_CFG0;
      r_shadow0   <= 16'h0000;
      r_shadow1   <= 16'h0000;
      r_refresh   <= 2'b11;
      r_ready     <= 1'b0;
    end else begin
      r_refresh <= w_refresh_nxt;
      if (w_next == ST_IDLE) r_ready <= 1'b1;
      if (w_issue) begin
        r_unit      <= w_issue_unit;
        r_last_unit <= w_issue_unit;
        r_cmd       <= w_cmd;
        r_d0        <= w_payload[7:0];
        r_d1        <= w_payload[15:8];
        r_after     <= w_after;
        if (w_cmd == CMD_OUTPUT_PORT0) begin
          if (w_issue_unit) r_shadow1 <= w_payload;
          else              r_shadow0 <= w_payload;
        end
      end
    end
  end

  assign unit_o    = r_unit;
  assign command_o = r_cmd;
  assign data_0_o  = r_d0;
  assign data_1_o  = r_d1;
  assign ready_o   = r_ready;
endmodule

// File: tb/tb_i2c_tca6416a_sequencer.sv
// Directed bench for i2c_tca6416a_sequencer with a behavioural writer that accepts on the phase-3
// strobe, logs each transaction and returns stop_i a fixed number of cycles later.
module tb_i2c_tca6416a_sequencer;
  localparam int CLOCK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] o0p0, o0p1, o1p0, o1p1;
  logic       refresh;
  logic       stop = 1'b0;
  logic [1:0] phase;
  logic       inc, unit, start, ready, busy;
  logic [7:0] cmd, d0, d1;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          wcnt   = 0;
  int          n_stop = 0;
  logic [24:0] cur;
  logic [24:0] q[$];

  always #5 clk = ~clk;

  i2c_tca6416a_sequencer #(
    .CLOCK_DIV   (CLOCK_DIV),
    .UNIT0_CONFIG(16'h12F0),
    .UNIT1_CONFIG(16'h00FF)
  ) dut (
    .clock_i        (clk),
    .reset_n_i      (rst_n),
    .out0_p0_i      (o0p0),
    .out0_p1_i      (o0p1),
    .out1_p0_i      (o1p0),
    .out1_p1_i      (o1p1),
    .refresh_i      (refresh),
    .stop_i         (stop),
    .bit_phase_o    (phase),
    .bit_phase_inc_o(inc),
    .unit_o         (unit),
    .command_o      (cmd),
    .data_0_o       (d0),
    .data_1_o       (d1),
    .start_o        (start),
    .ready_o        (ready),
    .busy_o         (busy)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Writer model: payload must hold steady from acceptance until stop.
  always @(negedge clk) begin
    if (!rst_n) begin
      wcnt = 0;
      stop = 1'b0;
    end else begin
      stop = 1'b0;
      if (wcnt > 0) begin
        check_vec("hold", {unit, cmd, d0, d1}, cur);
        wcnt--;
        if (wcnt == 0) begin
          stop = 1'b1;
          n_stop++;
        end
      end else if (start && phase == 2'd3 && inc) begin
        cur = {unit, cmd, d0, d1};
        q.push_back(cur);
        wcnt = 12;
      end
    end
  end

  task automatic wait_done(input string tag, input int n);
    int t;
    t = 0;
    while (!(q.size() >= n && !busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_vec({tag, "_timeout"}, t < 2000, 1);
    repeat (60) @(negedge clk);
    check_vec({tag, "_count"}, q.size(), n);
  endtask

  task automatic expect_txn(input string tag, input logic u, input logic [7:0] c,
                            input logic [7:0] a, input logic [7:0] b);
    logic [24:0] t;
    t = 'x;
    if (q.size() > 0) t = q.pop_front();
    check_vec(tag, t, {u, c, a, b});
  endtask

  initial begin
    int          k;
    int          s0;
    logic [2:0]  last;

    rst_n   = 1'b0;
    refresh = 1'b0;
    o0p0 = 8'h11; o0p1 = 8'h22; o1p0 = 8'h33; o1p1 = 8'h44;
    repeat (2) @(negedge clk);
    check_vec("rst_ctl", {start, busy, ready, inc, phase, unit}, 0);
    check_vec("rst_dat", {cmd, d0, d1}, 0);

    rst_n = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!inc && k < 50);
    check_vec("first_strobe", k, 4);
    check_vec("phase0", phase, 0);
    for (int i = 1; i < 5; i++) begin
      k = 0;
      do begin @(negedge clk); k++; end while (!inc && k < 50);
      check_vec($sformatf("strobe_gap%0d", i), k, 4);
      check_vec($sformatf("phase%0d", i), phase, i % 4);
    end

    wait_done("init", 4);
    expect_txn("init_cfg0", 1'b0, 8'h06, 8'hF0, 8'h12);
    expect_txn("init_cfg1", 1'b1, 8'h06, 8'hFF, 8'h00);
    expect_txn("init_out0", 1'b0, 8'h02, 8'h11, 8'h22);
    expect_txn("init_out1", 1'b1, 8'h02, 8'h33, 8'h44);
    check_vec("init_ready", ready, 1);

    o1p0 = 8'hA5;
    @(negedge clk);
    check_vec("a5_launch", {busy, start, unit, cmd, d0, d1}, {1'b1, 1'b1, 1'b1, 8'h02, 8'hA5, 8'h44});
    k = 0; last = 3'b000; s0 = n_stop;
    while (start && k < 100) begin last = {phase, inc}; @(negedge clk); k++; end
    check_vec("a5_release", last, {2'd3, 1'b1});
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    check_vec("a5_busy_stop", n_stop - s0, 1);
    wait_done("a5", 1);
    expect_txn("a5_txn", 1'b1, 8'h02, 8'hA5, 8'h44);

    o0p0 = 8'h5A;
    wait_done("u0", 1);
    expect_txn("u0_txn", 1'b0, 8'h02, 8'h5A, 8'h22);

    o0p1 = 8'h3C; o1p1 = 8'h77;
    wait_done("both", 2);
    expect_txn("both_first", 1'b1, 8'h02, 8'hA5, 8'h77);
    expect_txn("both_second", 1'b0, 8'h02, 8'h5A, 8'h3C);

    o0p0 = 8'h66;
    k = 0;
    do begin @(negedge clk); k++; end while (!(busy && !start) && k < 200);
    check_vec("refr_wait_stop", busy && !start, 1);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    wait_done("refr", 3);
    expect_txn("refr_cur", 1'b0, 8'h02, 8'h66, 8'h3C);
    expect_txn("refr_u1", 1'b1, 8'h02, 8'hA5, 8'h77);
    expect_txn("refr_u0", 1'b0, 8'h02, 8'h66, 8'h3C);
    check_vec("ready_hold", ready, 1);

    o1p0 = 8'h99;
    @(negedge clk);
    check_vec("rl_launch", {busy, start}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check_vec("rl_async", {busy, start, ready, unit}, 0);
    check_vec("rl_async_dat", {cmd, d0, d1}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done("reinit", 4);
    expect_txn("re_cfg0", 1'b0, 8'h06, 8'hF0, 8'h12);
    expect_txn("re_cfg1", 1'b1, 8'h06, 8'hFF, 8'h00);
    expect_txn("re_out0", 1'b0, 8'h02, 8'h66, 8'h3C);
    expect_txn("re_out1", 1'b1, 8'h02, 8'h99, 8'h77);
    check_vec("re_ready", ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
